// File: rtl/icmp_pkg.sv
// Shared ICMP constants, IP user-field layout, parse states and the descriptor payload.
package icmp_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned KEEP_W   = 8;
  localparam int unsigned USER_W   = 56;

  localparam logic [7:0] ICMP_PROTO    = 8'd1;
  localparam logic [7:0] ICMP_ECHO_REQ = 8'd8;
  localparam logic [7:0] ICMP_ECHO_REP = 8'd0;

  localparam int unsigned USER_LEN_LSB   = 40;
  localparam int unsigned USER_MF_BIT    = 37;
  localparam int unsigned USER_PROTO_LSB = 29;
  localparam int unsigned USER_OFF_LSB   = 16;
  localparam int unsigned USER_OFF_W     = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_SKIP = 2'd2
  } parse_state_e;

  typedef struct packed {
    logic [7:0]  icmp_type;
    logic [7:0]  code;
    logic [15:0] id;
    logic [15:0] seq;
    logic [15:0] len;
  } icmp_desc_t;

  function automatic logic [3:0] keep_popcount(input logic [KEEP_W-1:0] keep);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEEP_W; i++) cnt = cnt + 4'(keep[i]);
    return cnt;
  endfunction

  // Sum of the four big-endian 16-bit words of a beat, disabled bytes zeroed.
  function automatic logic [17:0] beat_word_sum(input logic [DATA_W-1:0] data,
                                                input logic [KEEP_W-1:0] keep);
    logic [DATA_W-1:0] masked;
    logic [17:0]       sum;
    for (int i = 0; i < KEEP_W; i++) masked[i*8 +: 8] = keep[i] ? data[i*8 +: 8] : 8'h00;
    sum = '0;
    for (int w = 0; w < 4; w++) sum = sum + 18'(masked[w*16 +: 16]);
    return sum;
  endfunction

endpackage

// File: rtl/icmp_desc_fifo.sv
// Synchronous descriptor FIFO with a registered head entry and registered valid/full flags.
module icmp_desc_fifo
  import icmp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  icmp_desc_t i_data,
  input  logic       i_pop,
  output logic       o_valid,
  output icmp_desc_t o_head,
  output logic       o_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  icmp_desc_t       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  icmp_desc_t       head_q, head_d;
  logic             valid_q, valid_d, full_q, full_d;
  logic             pop, push_ok;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop      = i_pop && valid_q;
    push_ok  = i_push && (!full_q || pop);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    count_d  = count_q + OCC_W'(push_ok) - OCC_W'(pop);
    valid_d  = count_d != '0;
    full_d   = count_d == OCC_W'(DEPTH);
    head_d   = head_q;
    if (push_ok && (count_q - OCC_W'(pop)) == '0) head_d = i_data;
    else if (pop)                                  head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_valid = valid_q;
  assign o_head  = head_q;
  assign o_full  = full_q;

endmodule

// File: rtl/icmp_rx_desc_queue.sv
// ICMP echo RX parser: classifies, length/checksum-checks and queues echo descriptors.
// Checksum verification is built only when ICMP_RX_CSUM_CHECK_EN is defined.
module icmp_rx_desc_queue
  import icmp_pkg::*;
#(
  parameter int unsigned DESC_DEPTH   = 4,
  parameter bit          ACCEPT_REPLY = 1'b0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] s_axis_ip_data,
  input  logic [USER_W-1:0] s_axis_ip_user,
  input  logic [KEEP_W-1:0] s_axis_ip_keep,
  input  logic              s_axis_ip_last,
  input  logic              s_axis_ip_valid,
  output logic              m_desc_valid,
  input  logic              m_desc_ready,
  output logic [7:0]        m_desc_type,
  output logic [7:0]        m_desc_code,
  output logic [15:0]       m_desc_id,
  output logic [15:0]       m_desc_seq,
  output logic [15:0]       m_desc_len,
  output logic [CNT_W-1:0]  o_rx_cnt,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic [CNT_W-1:0]  o_ovf_cnt
);

  parse_state_e     state_q, state_d;
  logic             type_ok, hdr_match, take_first, take_body, snap_en;
  logic [7:0]       beat_type;
  icmp_desc_t       hdr_q, hdr_d;
  logic [15:0]      cnt_q, cnt_d, ulen_q, ulen_d;
  logic             s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  icmp_desc_t       s1_desc_q, s1_desc_d, s2_desc_q, s2_desc_d;
  logic [15:0]      s1_ulen_q, s1_ulen_d, s2_ulen_q, s2_ulen_d;
  logic             csum_ok, pass, push, pop, ovf, err_inc, rx_inc;
  logic             fifo_valid, fifo_full;
  icmp_desc_t       fifo_head;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, err_cnt_q, err_cnt_d, ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    beat_type = s_axis_ip_data[63:56];
    type_ok   = (beat_type == ICMP_ECHO_REQ) || (ACCEPT_REPLY && beat_type == ICMP_ECHO_REP);
    hdr_match = (s_axis_ip_user[USER_PROTO_LSB +: 8] == ICMP_PROTO)
             && !s_axis_ip_user[USER_MF_BIT]
             && (s_axis_ip_user[USER_OFF_LSB +: USER_OFF_W] == '0)
             && type_ok;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (s_axis_ip_valid) begin
      case (state_q)
        ST_IDLE:          if (!s_axis_ip_last) state_d = hdr_match ? ST_BODY : ST_SKIP;
        ST_BODY, ST_SKIP: if (s_axis_ip_last)  state_d = ST_IDLE;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    take_first = 1'b0;
    take_body  = 1'b0;
    case (state_q)
      ST_IDLE: take_first = s_axis_ip_valid && hdr_match;
      ST_BODY: take_body  = s_axis_ip_valid;
      default: ;
    endcase
    snap_en = (take_first || take_body) && s_axis_ip_last;
  end

  // Header/length capture and the snapshot into the two-stage check pipeline.
  always_comb begin
    hdr_d  = hdr_q;
    cnt_d  = cnt_q;
    ulen_d = ulen_q;
    if (take_first) begin
      hdr_d.icmp_type = s_axis_ip_data[63:56];
      hdr_d.code      = s_axis_ip_data[55:48];
      hdr_d.id        = s_axis_ip_data[31:16];
      hdr_d.seq       = s_axis_ip_data[15:0];
      hdr_d.len       = '0;
      cnt_d           = 16'(keep_popcount(s_axis_ip_keep));
      ulen_d          = s_axis_ip_user[USER_LEN_LSB +: 16];
    end else if (take_body) begin
      cnt_d = cnt_q + 16'(keep_popcount(s_axis_ip_keep));
    end
    s1_vld_d      = snap_en;
    s1_desc_d     = s1_desc_q;
    s1_ulen_d     = s1_ulen_q;
    if (snap_en) begin
      s1_desc_d     = hdr_d;
      s1_desc_d.len = cnt_d;
      s1_ulen_d     = ulen_d;
    end
    s2_vld_d  = s1_vld_q;
    s2_desc_d = s1_desc_q;
    s2_ulen_d = s1_ulen_q;
  end

`ifdef ICMP_RX_CSUM_CHECK_EN
  logic [31:0] sum_q, sum_d, s1_sum_q, s1_sum_d;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic        s2_csum_ok_q, s2_csum_ok_d;

  always_comb begin
    sum_d = sum_q;
    if (take_first)     sum_d = 32'(beat_word_sum(s_axis_ip_data, s_axis_ip_keep));
    else if (take_body) sum_d = sum_q + 32'(beat_word_sum(s_axis_ip_data, s_axis_ip_keep));
    s1_sum_d     = snap_en ? sum_d : s1_sum_q;
    fold1        = 17'(s1_sum_q[31:16]) + 17'(s1_sum_q[15:0]);
    fold2        = fold1[15:0] + 16'(fold1[16]);
    s2_csum_ok_d = fold2 == 16'hFFFF;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sum_q        <= '0;
      s1_sum_q     <= '0;
      s2_csum_ok_q <= 1'b0;
    end else begin
      sum_q        <= sum_d;
      s1_sum_q     <= s1_sum_d;
      s2_csum_ok_q <= s2_csum_ok_d;
    end
  end

  assign csum_ok = s2_csum_ok_q;
`else
  logic unused_csum_field;
  assign unused_csum_field = ^s_axis_ip_data[47:32];
  assign csum_ok = 1'b1;
`endif

  logic unused_user;
  assign unused_user = ^{s_axis_ip_user[39:38], s_axis_ip_user[15:0]};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hdr_q     <= '0;
      cnt_q     <= '0;
      ulen_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_desc_q <= '0;
      s1_ulen_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_desc_q <= '0;
      s2_ulen_q <= '0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else begin
      hdr_q     <= hdr_d;
      cnt_q     <= cnt_d;
      ulen_q    <= ulen_d;
      s1_vld_q  <= s1_vld_d;
      s1_desc_q <= s1_desc_d;
      s1_ulen_q <= s1_ulen_d;
      s2_vld_q  <= s2_vld_d;
      s2_desc_q <= s2_desc_d;
      s2_ulen_q <= s2_ulen_d;
      rx_cnt_q  <= rx_cnt_d;
      err_cnt_q <= err_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Stage-2 verdict, FIFO push and saturating statistics.
  always_comb begin
    pass      = csum_ok && (s2_desc_q.len == s2_ulen_q) && (s2_desc_q.len >= 16'd8);
    push      = s2_vld_q && pass;
    err_inc   = s2_vld_q && !pass;
    pop       = fifo_valid && m_desc_ready;
    ovf       = push && fifo_full && !pop;
    rx_inc    = push && !ovf;
    rx_cnt_d  = rx_cnt_q  + CNT_W'(rx_inc  && (rx_cnt_q  != '1));
    err_cnt_d = err_cnt_q + CNT_W'(err_inc && (err_cnt_q != '1));
    ovf_cnt_d = ovf_cnt_q + CNT_W'(ovf     && (ovf_cnt_q != '1));
  end

  icmp_desc_fifo #(.DEPTH(DESC_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (s2_desc_q),
    .i_pop   (m_desc_ready),
    .o_valid (fifo_valid),
    .o_head  (fifo_head),
    .o_full  (fifo_full)
  );

  assign m_desc_valid = fifo_valid;
  assign m_desc_type  = fifo_head.icmp_type;
  assign m_desc_code  = fifo_head.code;
  assign m_desc_id    = fifo_head.id;
  assign m_desc_seq   = fifo_head.seq;
  assign m_desc_len   = fifo_head.len;
  assign o_rx_cnt     = rx_cnt_q;
  assign o_err_cnt    = err_cnt_q;
  assign o_ovf_cnt    = ovf_cnt_q;

endmodule

// File: tb/tb_icmp_rx_desc_queue.sv
// Bench for icmp_rx_desc_queue: two instances (echo replies rejected / accepted) against a queue model.
`timescale 1ns/1ps
module tb_icmp_rx_desc_queue;
  import icmp_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 16;
  localparam int unsigned MAXC  = (1 << CW) - 1;
`ifdef ICMP_RX_CSUM_CHECK_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif
  localparam int RX3  = CS_EN ? 5 : 6;
  localparam int ERR3 = CS_EN ? 1 : 0;

  logic clk = 1'b0;
  logic rst_n;
  logic [63:0] ip_data;
  logic [55:0] ip_user;
  logic [7:0]  ip_keep;
  logic ip_last, ip_valid, ready;

  logic [1:0]         d_valid;
  logic [1:0][7:0]    d_type, d_code;
  logic [1:0][15:0]   d_id, d_seq, d_len;
  logic [1:0][CW-1:0] d_rx, d_err, d_ovf;

  always #5 clk = ~clk;

  icmp_rx_desc_queue #(.DESC_DEPTH(DEPTH), .ACCEPT_REPLY(1'b0), .CNT_W(CW)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .s_axis_ip_data(ip_data), .s_axis_ip_user(ip_user), .s_axis_ip_keep(ip_keep),
    .s_axis_ip_last(ip_last), .s_axis_ip_valid(ip_valid),
    .m_desc_valid(d_valid[0]), .m_desc_ready(ready),
    .m_desc_type(d_type[0]), .m_desc_code(d_code[0]), .m_desc_id(d_id[0]),
    .m_desc_seq(d_seq[0]), .m_desc_len(d_len[0]),
    .o_rx_cnt(d_rx[0]), .o_err_cnt(d_err[0]), .o_ovf_cnt(d_ovf[0]));

  icmp_rx_desc_queue #(.DESC_DEPTH(DEPTH), .ACCEPT_REPLY(1'b1), .CNT_W(CW)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .s_axis_ip_data(ip_data), .s_axis_ip_user(ip_user), .s_axis_ip_keep(ip_keep),
    .s_axis_ip_last(ip_last), .s_axis_ip_valid(ip_valid),
    .m_desc_valid(d_valid[1]), .m_desc_ready(ready),
    .m_desc_type(d_type[1]), .m_desc_code(d_code[1]), .m_desc_id(d_id[1]),
    .m_desc_seq(d_seq[1]), .m_desc_len(d_len[1]),
    .o_rx_cnt(d_rx[1]), .o_err_cnt(d_err[1]), .o_ovf_cnt(d_ovf[1]));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int         due;
    bit         pass;
    icmp_desc_t d;
  } outcome_t;

  outcome_t    pend [2][$];
  icmp_desc_t  mq   [2][$];
  int unsigned m_rx [2];
  int unsigned m_err[2];
  int unsigned m_ovf[2];
  int          edge_n = 0;
  bit          chk_en = 1'b0;
  logic [7:0]  pb [0:127];

  // Internet checksum of pb[0..n-1]; odd trailing byte padded as the low byte.
  function automatic logic [15:0] m_sum(input int n);
    int unsigned s;
    s = 0;
    for (int k = 0; k < n; k += 2) s += 32'({pb[k], (k + 1 < n) ? pb[k+1] : 8'h00});
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return 16'(s);
  endfunction

  always @(posedge clk) begin : model_p
    outcome_t o;
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mq[i].delete();
        pend[i].delete();
        m_rx[i] = 0; m_err[i] = 0; m_ovf[i] = 0;
      end else begin
        if (mq[i].size() != 0 && ready) void'(mq[i].pop_front());
        while (pend[i].size() != 0 && pend[i][0].due == edge_n) begin
          o = pend[i].pop_front();
          if (!o.pass) begin
            if (m_err[i] < MAXC) m_err[i]++;
          end else if (mq[i].size() < DEPTH) begin
            mq[i].push_back(o.d);
            if (m_rx[i] < MAXC) m_rx[i]++;
          end else if (m_ovf[i] < MAXC) m_ovf[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("valid%0d", i), 64'(d_valid[i]), 64'(mq[i].size() != 0));
        if (mq[i].size() != 0)
          chk($sformatf("desc%0d", i), 64'({d_type[i], d_code[i], d_id[i], d_seq[i], d_len[i]}),
              64'(mq[i][0]));
        chk($sformatf("rx%0d", i),  64'(d_rx[i]),  64'(m_rx[i]));
        chk($sformatf("err%0d", i), 64'(d_err[i]), 64'(m_err[i]));
        chk($sformatf("ovf%0d", i), 64'(d_ovf[i]), 64'(m_ovf[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic build_echo(input logic [7:0] typ, input logic [15:0] id,
                            input logic [15:0] seq, input int n);
    logic [15:0] cs;
    pb[0] = typ;      pb[1] = 8'h00; pb[2] = 8'h00;    pb[3] = 8'h00;
    pb[4] = id[15:8]; pb[5] = id[7:0]; pb[6] = seq[15:8]; pb[7] = seq[7:0];
    for (int k = 8; k < n; k++) pb[k] = 8'(k * 7 + 3);
    cs = ~m_sum(n);
    pb[2] = cs[15:8];
    pb[3] = cs[7:0];
  endtask

  task automatic send(input int n, input logic [15:0] ulen, input logic [7:0] proto,
                      input bit mf, input logic [12:0] off, input int max_beats);
    int nb, beats;
    bit trunc, acc;
    logic [63:0] dat;
    logic [7:0]  kp;
    outcome_t    o;
    nb    = (n + 7) / 8;
    trunc = max_beats < nb;
    beats = trunc ? max_beats : nb;
    for (int b = 0; b < beats; b++) begin
      dat = '0;
      kp  = '0;
      for (int j = 0; j < 8; j++)
        if (b * 8 + j < n) begin
          dat[63 - 8*j -: 8] = pb[b*8 + j];
          kp[7 - j] = 1'b1;
        end
      ip_data  = dat;
      ip_keep  = kp;
      ip_user  = {ulen, 2'b00, mf, proto, off, 16'hABCD};
      ip_last  = !trunc && (b == nb - 1);
      ip_valid = 1'b1;
      if (ip_last) begin
        for (int i = 0; i < 2; i++) begin
          acc = (proto == 8'd1) && !mf && (off == 13'd0)
             && (pb[0] == 8'd8 || (i == 1 && pb[0] == 8'd0));
          if (acc) begin
            o.due  = edge_n + 3;
            o.pass = (!CS_EN || m_sum(n) == 16'hFFFF) && (n == int'(ulen)) && (n >= 8);
            o.d    = '{icmp_type: pb[0], code: pb[1], id: {pb[4], pb[5]},
                       seq: {pb[6], pb[7]}, len: 16'(n)};
            pend[i].push_back(o);
          end
        end
      end
      @(posedge clk); #1;
    end
    ip_valid = 1'b0;
    ip_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ip_valid = 1'b0; ip_last = 1'b0;
    ip_data = '0; ip_keep = '0; ip_user = '0; ready = 1'b1;
    idle(3);
    chk_en = 1'b1;
    chk("rst_valid", 64'(d_valid[0]), 64'd0);
    chk("rst_rx", 64'(d_rx[0]), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Checksum model pin: 08 00 xx xx 12 34 00 01 -> E5CA
    build_echo(8'd8, 16'h1234, 16'h0001, 8);
    chk("model_csum", 64'({pb[2], pb[3]}), 64'h0000E5CA);

    // Valid 64-byte echo request, descriptor appears exactly at T+3
    build_echo(8'd8, 16'h1234, 16'h0001, 64);
    send(64, 16'd64, 8'd1, 1'b0, 13'd0, 99);
    idle(1);
    chk("t2_valid", 64'(d_valid[0]), 64'd0);
    idle(1);
    chk("t3_valid", 64'(d_valid[0]), 64'd1);
    chk("t3_desc", 64'({d_type[0], d_code[0], d_id[0], d_seq[0], d_len[0]}),
        64'h0008_0012_3400_0100_40 >> 0);
    chk("t3_rx", 64'(d_rx[0]), 64'd1);
    idle(3);

    // Corrupted checksum byte
    build_echo(8'd8, 16'h1234, 16'h0001, 64);
    pb[2] = pb[2] ^ 8'h01;
    send(64, 16'd64, 8'd1, 1'b0, 13'd0, 99);
    idle(5);
    chk("bad_cs_err", 64'(d_err[0]), 64'(ERR3));
    chk("bad_cs_rx", 64'(d_rx[0]), 64'(CS_EN ? 1 : 2));

    // Five back-to-back requests into a 4-deep FIFO with no consumer
    ready = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      build_echo(8'd8, 16'h0042, 16'(s), 16);
      send(16, 16'd16, 8'd1, 1'b0, 13'd0, 99);
    end
    idle(5);
    chk("burst_ovf", 64'(d_ovf[0]), 64'd1);
    chk("burst_rx", 64'(d_rx[0]), 64'(RX3));
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("pop_valid", 64'(d_valid[0]), 64'd1);
      chk("pop_order", 64'(d_seq[0]), 64'(k + 1));
      @(posedge clk); #1;
    end
    chk("drained", 64'(d_valid[0]), 64'd0);
    idle(2);

    // Echo reply: dropped by dut0, queued by dut1
    build_echo(8'd0, 16'h0BEE, 16'h0009, 24);
    send(24, 16'd24, 8'd1, 1'b0, 13'd0, 99);
    idle(2);
    chk("rep_valid0", 64'(d_valid[0]), 64'd0);
    chk("rep_valid1", 64'(d_valid[1]), 64'd1);
    chk("rep_type1", 64'(d_type[1]), 64'd0);
    chk("rep_id1", 64'(d_id[1]), 64'h0BEE);
    idle(3);
    chk("rep_rx0", 64'(d_rx[0]), 64'(RX3));
    chk("rep_rx1", 64'(d_rx[1]), 64'(RX3 + 1));
    chk("rep_err0", 64'(d_err[0]), 64'(ERR3));

    // UDP, odd-length 61-byte request, fragment, back-to-back
    ready = 1'b0;
    build_echo(8'd8, 16'h0001, 16'h0001, 24);
    send(24, 16'd24, 8'd17, 1'b0, 13'd0, 99);
    build_echo(8'd8, 16'h0061, 16'h0003, 61);
    send(61, 16'd61, 8'd1, 1'b0, 13'd0, 99);
    build_echo(8'd8, 16'h0002, 16'h0002, 24);
    send(24, 16'd24, 8'd1, 1'b1, 13'd0, 99);
    idle(5);
    chk("mix_rx", 64'(d_rx[0]), 64'(RX3 + 1));
    chk("mix_err", 64'(d_err[0]), 64'(ERR3));
    chk("mix_len", 64'(d_len[0]), 64'd61);
    chk("mix_seq", 64'(d_seq[0]), 64'd3);
    ready = 1'b1;
    idle(3);
    chk("mix_drained", 64'(d_valid[0]), 64'd0);

    // Reset in the middle of a packet body, then a fresh request
    ready = 1'b0;
    build_echo(8'd8, 16'hDEAD, 16'h0005, 64);
    send(64, 16'd64, 8'd1, 1'b0, 13'd0, 2);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    build_echo(8'd8, 16'h0777, 16'h0077, 32);
    send(32, 16'd32, 8'd1, 1'b0, 13'd0, 99);
    idle(3);
    chk("post_rst_rx", 64'(d_rx[0]), 64'd1);
    chk("post_rst_err", 64'(d_err[0]), 64'd0);
    chk("post_rst_ovf", 64'(d_ovf[0]), 64'd0);
    chk("post_rst_seq", 64'(d_seq[0]), 64'h77);
    chk("post_rst_rx1", 64'(d_rx[1]), 64'd1);
    ready = 1'b1;
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
